// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The master side is the datapath; the slave side is the hazard unit.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  // Hazard sources observed in the pipeline
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegisterRd;
  logic [4:0]       IF_ID_RegisterRn1;
  logic [4:0]       IF_ID_RegisterRm2;
  logic             IF_ID_UsesRm;
  logic             MEM_BranchTaken;
  logic             MEM_MemRequest;
  logic             MEM_MemReady;

  // Pipeline sequencing controls
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             ControlBubble;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             MEM_WB_Bubble;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] LoadUseStalls;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           IF_ID_UsesRm, MEM_BranchTaken, MEM_MemRequest, MEM_MemReady,
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ControlBubble,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Bubble, MemTimeout,
           StallCycles, LoadUseStalls, FlushCount
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           IF_ID_UsesRm, MEM_BranchTaken, MEM_MemRequest, MEM_MemReady,
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ControlBubble,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Bubble, MemTimeout,
           StallCycles, LoadUseStalls, FlushCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory
// freeze with a timeout watchdog, and saturating stall/flush counters.
module hazard_control_unit #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ZERO_REG    = 31
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hif
);

  localparam int unsigned WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memTimeoutQ;
  logic [CNT_W-1:0]  stallCyclesQ;
  logic [CNT_W-1:0]  loadUseStallsQ;
  logic [CNT_W-1:0]  flushCountQ;

  logic memStall;
  logic loadUse;
  logic halted;
  logic loadUseStall;
  logic branchFlush;

  // Raw hazard conditions; XZR never produces a dependency
  assign memStall = hif.MEM_MemRequest & ~hif.MEM_MemReady;
  assign loadUse  = hif.ID_EX_MemRead
                  & (hif.ID_EX_RegisterRd != ZERO_IDX)
                  & ((hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRn1)
                     | (hif.IF_ID_UsesRm & (hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRm2)));

  assign halted       = (state == HALT);
  // Events that actually win priority this cycle
  assign loadUseStall = loadUse & ~memStall & ~hif.MEM_BranchTaken;
  assign branchFlush  = hif.MEM_BranchTaken & ~memStall;

  // Pipeline controls are combinational so the enables act in the same cycle
  always_comb begin
    hif.PCWrite       = 1'b1;
    hif.IF_ID_Write   = 1'b1;
    hif.ID_EX_Write   = 1'b1;
    hif.EX_MEM_Write  = 1'b1;
    hif.ControlBubble = 1'b0;
    hif.IF_ID_Flush   = 1'b0;
    hif.ID_EX_Flush   = 1'b0;
    hif.EX_MEM_Flush  = 1'b0;
    hif.MEM_WB_Bubble = 1'b0;

    if (reset || halted) begin
      hif.PCWrite       = 1'b0;
      hif.IF_ID_Write   = 1'b0;
      hif.ID_EX_Write   = 1'b0;
      hif.EX_MEM_Write  = 1'b0;
      hif.ControlBubble = 1'b1;
      hif.MEM_WB_Bubble = 1'b1;
    end else if (memStall) begin
      // Freeze everything up to MEM; a pending branch waits in MEM
      hif.PCWrite       = 1'b0;
      hif.IF_ID_Write   = 1'b0;
      hif.ID_EX_Write   = 1'b0;
      hif.EX_MEM_Write  = 1'b0;
      hif.MEM_WB_Bubble = 1'b1;
    end else if (hif.MEM_BranchTaken) begin
      hif.IF_ID_Flush   = 1'b1;
      hif.ID_EX_Flush   = 1'b1;
      hif.EX_MEM_Flush  = 1'b1;
    end else if (loadUse) begin
      hif.PCWrite       = 1'b0;
      hif.IF_ID_Write   = 1'b0;
      hif.ControlBubble = 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Sequencing FSM, memory watchdog and performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      waitCnt        <= '0;
      memTimeoutQ    <= 1'b0;
      stallCyclesQ   <= '0;
      loadUseStallsQ <= '0;
      flushCountQ    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (memStall) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // Ready is checked first so it always beats the timeout
          if (hif.MEM_MemReady || !hif.MEM_MemRequest) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_LIMIT) begin
            state       <= HALT;
            memTimeoutQ <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase

      if (!halted) begin
        stallCyclesQ   <= satInc(stallCyclesQ, memStall | loadUseStall);
        loadUseStallsQ <= satInc(loadUseStallsQ, loadUseStall);
        flushCountQ    <= satInc(flushCountQ, branchFlush);
      end
    end
  end

  assign hif.MemTimeout    = memTimeoutQ;
  assign hif.StallCycles   = stallCyclesQ;
  assign hif.LoadUseStalls = loadUseStallsQ;
  assign hif.FlushCount    = flushCountQ;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (CNT_W=3, MEM_TIMEOUT=4).
module tb_hazard_control_unit;

  localparam int unsigned CW = 3;

  // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ControlBubble,
  //  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Bubble}
  localparam logic [8:0] NORM = 9'b1111_0_000_0;
  localparam logic [8:0] MST  = 9'b0000_0_000_1;
  localparam logic [8:0] BRF  = 9'b1111_0_111_0;
  localparam logic [8:0] LUS  = 9'b0011_1_000_0;
  localparam logic [8:0] HLT  = 9'b0000_1_000_1;

  typedef struct packed {
    logic [8:0]    ctrl;
    logic [CW-1:0] sc;
    logic [CW-1:0] lu;
    logic [CW-1:0] fc;
    logic          to;
  } obs_t;

  logic clk;
  logic rst;
  obs_t expQ[$];
  int   tests;
  int   failed;

  hazard_control_unit_if #(.CNT_W(CW)) hif ();

  hazard_control_unit #(
    .CNT_W(CW),
    .MEM_TIMEOUT(4),
    .ZERO_REG(31)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .hif  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of stimulus, queue its expectation, then check it before the next edge
  task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic um,
                      input logic br, input logic rq, input logic ry,
                      input logic [8:0] ec, input int sc, input int lu, input int fc,
                      input logic to);
    obs_t e;
    obs_t got;
    hif.ID_EX_MemRead     = mr;
    hif.ID_EX_RegisterRd  = rd;
    hif.IF_ID_RegisterRn1 = rn;
    hif.IF_ID_RegisterRm2 = rm;
    hif.IF_ID_UsesRm      = um;
    hif.MEM_BranchTaken   = br;
    hif.MEM_MemRequest    = rq;
    hif.MEM_MemReady      = ry;
    e.ctrl = ec;
    e.sc   = CW'(sc);
    e.lu   = CW'(lu);
    e.fc   = CW'(fc);
    e.to   = to;
    expQ.push_back(e);
    #3;
    got.ctrl = {hif.PCWrite, hif.IF_ID_Write, hif.ID_EX_Write, hif.EX_MEM_Write,
                hif.ControlBubble, hif.IF_ID_Flush, hif.ID_EX_Flush, hif.EX_MEM_Flush,
                hif.MEM_WB_Bubble};
    got.sc = hif.StallCycles;
    got.lu = hif.LoadUseStalls;
    got.fc = hif.FlushCount;
    got.to = hif.MemTimeout;
    e = expQ.pop_front();
    tests++;
    assert (got === e) else begin
      failed++;
      $error("FAIL %s: observed ctrl=%b stall=%0d lu=%0d flush=%0d to=%b, expected ctrl=%b stall=%0d lu=%0d flush=%0d to=%b",
             tag, got.ctrl, got.sc, got.lu, got.fc, got.to, e.ctrl, e.sc, e.lu, e.fc, e.to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [8:0] ec, input int sc, input int lu,
                      input int fc, input logic to);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, sc, lu, fc, to);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    idle(tag, HLT, 0, 0, 0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    hif.ID_EX_MemRead     = 1'b0;
    hif.ID_EX_RegisterRd  = 5'd0;
    hif.IF_ID_RegisterRn1 = 5'd0;
    hif.IF_ID_RegisterRm2 = 5'd0;
    hif.IF_ID_UsesRm      = 1'b0;
    hif.MEM_BranchTaken   = 1'b0;
    hif.MEM_MemRequest    = 1'b0;
    hif.MEM_MemReady      = 1'b0;
    @(posedge clk);
    #1;

    // Load-use detection, XZR and unused-Rm filtering
    doReset("reset_a");
    idle("idle_a", NORM, 0, 0, 0, 1'b0);
    step("lu_rn1", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LUS, 0, 0, 0, 1'b0);
    idle("lu_count", NORM, 1, 1, 0, 1'b0);
    step("xzr", 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1, 1, 0, 1'b0);
    step("rm_unused", 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1, 1, 0, 1'b0);
    step("rm_used", 1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LUS, 1, 1, 0, 1'b0);
    idle("rm_count", NORM, 2, 2, 0, 1'b0);

    // Taken branch beats load-use
    doReset("reset_b");
    step("br_vs_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BRF, 0, 0, 0, 1'b0);
    idle("br_count", NORM, 0, 0, 1, 1'b0);

    // Memory wait holds a taken branch until ready
    doReset("reset_c");
    step("mw_br1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MST, 0, 0, 0, 1'b0);
    step("mw_br2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MST, 1, 0, 0, 1'b0);
    step("mw_br3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MST, 2, 0, 0, 1'b0);
    step("mw_br_rdy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BRF, 3, 0, 0, 1'b0);
    idle("mw_br_count", NORM, 3, 0, 1, 1'b0);

    // Timeout: five stall cycles then HALT until reset
    doReset("reset_d");
    for (int i = 0; i < 5; i++)
      step("to_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST, i, 0, 0, 1'b0);
    step("halt1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HLT, 5, 0, 0, 1'b1);
    step("halt_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, HLT, 5, 0, 0, 1'b1);
    idle("halt_idle", HLT, 5, 0, 0, 1'b1);
    doReset("reset_halt");
    idle("after_halt", NORM, 0, 0, 0, 1'b0);

    // Memstall beats load-use; ready when wait count hits the limit still resumes
    doReset("reset_e");
    step("ms_vs_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST, 0, 0, 0, 1'b0);
    for (int i = 1; i < 4; i++)
      step("ms_hold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MST, i, 0, 0, 1'b0);
    step("rdy_at_limit", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM, 4, 0, 0, 1'b0);
    idle("no_timeout", NORM, 4, 0, 0, 1'b0);

    // Saturation of the 3-bit counters
    doReset("reset_f");
    for (int i = 0; i < 10; i++)
      step("sat_lu", 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LUS,
           (i > 7) ? 7 : i, (i > 7) ? 7 : i, 0, 1'b0);
    idle("sat_hold", NORM, 7, 7, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
